jk_register_bank: RTL and testbench

//  - WIDTH-bit register bank built from per-bit JK cells; the generalised successor of the single JK flip-flop.
//  - Supports parallel load, per-bit JK, up/down count, serial shift left/right, clear and complement, all selected by iMode.
//  - Used for SAP-2 datapath registers: accumulator/temp, program counter, shift/rotate staging.
//  - Operates on the falling edge of iClk, matching the rest of the SAP-2 register file.

---
 rtl/jk_register_bank.sv | 115 +++++++++++
 tb/tb_jk_register_bank.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// rtl/jk_register_bank.sv - WIDTH-bit JK register bank: load, JK, count, shift, clear, complement on negedge iClk.
// Optional status flags (oCarry, oZero) are built only when JKREG_STATUS_FLAGS_EN is defined.
module jk_register_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iEnable,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iD,
    input  logic [2:0]       iMode,
    input  logic [WIDTH-1:0] iJ,
    input  logic [WIDTH-1:0] iK,
    input  logic             iSerIn,
    output logic [WIDTH-1:0] oQ,
    output logic [WIDTH-1:0] oQBar,
    output logic             oCarry,
    output logic             oZero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_JK   = 3'b001;
    localparam logic [2:0] MODE_UP   = 3'b010;
    localparam logic [2:0] MODE_DOWN = 3'b011;
    localparam logic [2:0] MODE_SHL  = 3'b100;
    localparam logic [2:0] MODE_SHR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_CPL  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] jkNext;
    logic [WIDTH-1:0] nextQ;

    // Each bit behaves as an independent JK cell.
    always_comb begin
        jkNext = qReg;
        for (int b = 0; b < WIDTH; b++) begin
            case ({iJ[b], iK[b]})
                2'b00:   jkNext[b] = qReg[b];
                2'b01:   jkNext[b] = 1'b0;
                2'b10:   jkNext[b] = 1'b1;
                default: jkNext[b] = ~qReg[b];
            endcase
        end
    end

    always_comb begin
        nextQ = qReg;
        if (iLoad) begin
            nextQ = iD;
        end else begin
            case (iMode)
                MODE_HOLD: nextQ = qReg;
                MODE_JK:   nextQ = jkNext;
                MODE_UP:   nextQ = qReg + ONE;
                MODE_DOWN: nextQ = qReg - ONE;
                MODE_SHL:  nextQ = {qReg[WIDTH-2:0], iSerIn};
                MODE_SHR:  nextQ = {iSerIn, qReg[WIDTH-1:1]};
                MODE_CLR:  nextQ = '0;
                default:   nextQ = ~qReg;
            endcase
        end
    end

    always_ff @(negedge iClk) begin
        if (!iReset) begin
            qReg <= RESET_VALUE;
        end else if (iEnable) begin
            qReg <= nextQ;
        end
    end

    assign oQ    = qReg;
    assign oQBar = ~qReg;

`ifdef JKREG_STATUS_FLAGS_EN
    logic nextCarry;
    logic carryReg;
    logic zeroReg;

    always_comb begin
        nextCarry = 1'b0;
        if (!iLoad) begin
            case (iMode)
                MODE_UP:   nextCarry = (qReg == '1);
                MODE_DOWN: nextCarry = (qReg == '0);
                MODE_SHL:  nextCarry = qReg[WIDTH-1];
                MODE_SHR:  nextCarry = qReg[0];
                default:   nextCarry = 1'b0;
            endcase
        end
    end

    // Flags track the value being written so they land on the same edge as oQ.
    always_ff @(negedge iClk) begin
        if (!iReset) begin
            carryReg <= 1'b0;
            zeroReg  <= (RESET_VALUE == '0);
        end else if (iEnable) begin
            carryReg <= nextCarry;
            zeroReg  <= (nextQ == '0);
        end
    end

    assign oCarry = carryReg;
    assign oZero  = zeroReg;
`else
    assign oCarry = 1'b0;
    assign oZero  = 1'b0;
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
// tb/tb_jk_register_bank.sv - Vector table plus scoreboard bench for jk_register_bank (WIDTH=8, RESET_VALUE=0).
module tb_jk_register_bank;

`ifdef JKREG_STATUS_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    localparam logic [2:0] HOLD = 3'b000, JK = 3'b001, UP = 3'b010, DN = 3'b011;
    localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, CLR = 3'b110, CPL = 3'b111;

    logic       iClk = 1'b0;
    logic       iReset, iEnable, iLoad, iSerIn;
    logic [7:0] iD, iJ, iK;
    logic [2:0] iMode;
    logic [7:0] oQ, oQBar;
    logic       oCarry, oZero;

    jk_register_bank #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .iClk(iClk), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad),
        .iD(iD), .iMode(iMode), .iJ(iJ), .iK(iK), .iSerIn(iSerIn),
        .oQ(oQ), .oQBar(oQBar), .oCarry(oCarry), .oZero(oZero)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic       rst, en, ld;
        logic [7:0] d;
        logic [2:0] mode;
        logic [7:0] j, k;
        logic       ser;
        logic [7:0] q;
        logic       c, z;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       c, z;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   passCount = 0;
    int   totalCount = 0;

    function automatic vec_t mk(logic rst, logic en, logic ld, logic [7:0] d, logic [2:0] mode,
                                logic [7:0] j, logic [7:0] k, logic ser,
                                logic [7:0] q, logic c, logic z);
        vec_t v;
        v.rst = rst; v.en = en; v.ld = ld; v.d = d; v.mode = mode;
        v.j = j; v.k = k; v.ser = ser; v.q = q; v.c = c; v.z = z;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        totalCount++;
        if (act === req) passCount++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Drive one edge worth of inputs, queue the expectation, then compare after the negedge.
    task automatic step(string name, logic rst, logic en, logic ld, logic [7:0] d, logic [2:0] mode,
                        logic [7:0] j, logic [7:0] k, logic ser,
                        logic [7:0] q, logic c, logic z);
        exp_t e;
        iReset = rst; iEnable = en; iLoad = ld; iD = d; iMode = mode;
        iJ = j; iK = k; iSerIn = ser;
        e.name = name; e.q = q; e.c = FLAGS ? c : 1'b0; e.z = FLAGS ? z : 1'b0;
        sb.push_back(e);
        @(negedge iClk);
        #2;
        if (sb.size() == 0) begin
            totalCount++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({e.name, ".q"}, oQ, e.q);
            check({e.name, ".qbar"}, oQBar, ~e.q);
            check({e.name, ".carry"}, {7'b0, oCarry}, {7'b0, e.c});
            check({e.name, ".zero"}, {7'b0, oZero}, {7'b0, e.z});
        end
    endtask

    initial begin
        logic [7:0] mq;
        logic       mc;
        iReset = 1'b0; iEnable = 1'b0; iLoad = 1'b0; iD = '0; iMode = HOLD;
        iJ = '0; iK = '0; iSerIn = 1'b0;
        #2;

        //                rst en ld d      mode  j      k      s   q      c  z
        vecs.push_back(mk(0, 1, 1, 8'hAA, HOLD, 8'h00, 8'h00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 1, 8'h5C, HOLD, 8'h00, 8'h00, 0, 8'h5C, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h11, CPL,  8'hFF, 8'hFF, 0, 8'h5C, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'hF0, HOLD, 8'h00, 8'h00, 0, 8'hF0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, JK,   8'h0C, 8'hC3, 0, 8'h3C, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, JK,   8'hFF, 8'hFF, 0, 8'hC3, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'hFE, UP,   8'h00, 8'h00, 0, 8'hFE, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, UP,   8'h00, 8'h00, 0, 8'hFF, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, UP,   8'h00, 8'h00, 0, 8'h00, 1, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, DN,   8'h00, 8'h00, 0, 8'h00, 1, 1));
        vecs.push_back(mk(1, 1, 0, 8'h00, DN,   8'h00, 8'h00, 0, 8'hFF, 1, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, DN,   8'h00, 8'h00, 0, 8'hFE, 0, 0));
        vecs.push_back(mk(1, 1, 1, 8'h81, SHL,  8'h00, 8'h00, 0, 8'h81, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, SHL,  8'h00, 8'h00, 0, 8'h02, 1, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, SHR,  8'h00, 8'h00, 1, 8'h81, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, SHR,  8'h00, 8'h00, 0, 8'h40, 1, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, HOLD, 8'hFF, 8'h00, 1, 8'h40, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, CPL,  8'h00, 8'h00, 0, 8'hBF, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, CLR,  8'h00, 8'h00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h00, DN,   8'h00, 8'h00, 0, 8'hFF, 1, 0));
        vecs.push_back(mk(1, 1, 1, 8'h00, DN,   8'h00, 8'h00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 1, 8'h37, UP,   8'h00, 8'h00, 0, 8'h37, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, UP,   8'h00, 8'h00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h00, UP,   8'h00, 8'h00, 0, 8'h01, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].d,
                 vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].ser,
                 vecs[i].q, vecs[i].c, vecs[i].z);
        end

        // Full up-count lap from a loaded value with a reference model, crossing the wrap once.
        step("lap_load", 1, 1, 1, 8'hF8, HOLD, 0, 0, 0, 8'hF8, 0, 0);
        mq = 8'hF8;
        for (int n = 0; n < 260; n++) begin
            mc = (mq == 8'hFF);
            mq = mq + 8'h01;
            step($sformatf("lap%0d", n), 1, 1, 0, 8'h00, UP, 0, 0, 0, mq, mc, mq == 8'h00);
        end

        // Shift-left a 1 all the way out; carry appears only when it falls off bit 7.
        step("walk_load", 1, 1, 1, 8'h01, HOLD, 0, 0, 0, 8'h01, 0, 0);
        mq = 8'h01;
        for (int n = 0; n < 9; n++) begin
            mc = mq[7];
            mq = {mq[6:0], 1'b0};
            step($sformatf("walk%0d", n), 1, 1, 0, 8'h00, SHL, 0, 0, 0, mq, mc, mq == 8'h00);
        end

        if (sb.size() != 0) begin
            totalCount++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
